// File: rtl/nes_controller_responder_if.sv
// Serial bus between an NES console (or host reader) and a controller.
// The console drives latch and pulse, and the pad answers on data.
interface nes_controller_responder_if;
  logic nes_latch;
  logic nes_pulse;
  logic nes_data;

  modport master (
    output nes_latch,
    output nes_pulse,
    input  nes_data
  );

  modport slave (
    input  nes_latch,
    input  nes_pulse,
    output nes_data
  );
endinterface

// File: rtl/nes_controller_responder.sv
// NES controller emulation. It debounces the raw buttons and answers console
// latch/pulse reads with an active-low serial button frame (A first).
module nes_controller_responder #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [7:0]                       buttons,
  nes_controller_responder_if.slave        nes,
  output logic                             frame_done,
  output logic [7:0]                       poll_count
);

  localparam logic [15:0] STABLE_MAX = DEBOUNCE_CYCLES - 16'd1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [7:0]  btn_meta;
  logic [7:0]  btn_sync;
  logic [7:0]  btn_prev;
  logic        latch_meta;
  logic        latch_sync;
  logic        latch_prev;
  logic        pulse_meta;
  logic        pulse_sync;
  logic        pulse_prev;
  logic [2:0]  warm;

  logic        latch_rise;
  logic        latch_fall;
  logic        pulse_rise;

  logic [15:0] stable_cnt;
  logic [15:0] stable_next;
  logic [7:0]  debounced;

  logic [7:0]  shift_reg;
  logic [2:0]  bit_idx;
  logic        nes_data_q;

  logic        load_shift;
  logic        do_shift;
  logic        start_frame;
  logic        finish_frame;
  logic        nes_data_next;
  logic        frame_done_next;

  // warm fills with ones after reset. The strobes stay masked until the
  // delayed copies hold real pin values, so a latch held high through
  // reset release does not look like a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta   <= 8'h00;
      btn_sync   <= 8'h00;
      btn_prev   <= 8'h00;
      latch_meta <= 1'b0;
      latch_sync <= 1'b0;
      latch_prev <= 1'b0;
      pulse_meta <= 1'b0;
      pulse_sync <= 1'b0;
      pulse_prev <= 1'b0;
      warm       <= 3'b000;
    end else begin
      btn_meta   <= buttons;
      btn_sync   <= btn_meta;
      btn_prev   <= btn_sync;
      latch_meta <= nes.nes_latch;
      latch_sync <= latch_meta;
      latch_prev <= latch_sync;
      pulse_meta <= nes.nes_pulse;
      pulse_sync <= pulse_meta;
      pulse_prev <= pulse_sync;
      warm       <= {warm[1:0], 1'b1};
    end
  end

  assign latch_rise = warm[2] &  latch_sync & ~latch_prev;
  assign latch_fall = warm[2] & ~latch_sync &  latch_prev;
  assign pulse_rise = warm[2] &  pulse_sync & ~pulse_prev;

  // Load on the cycle the counter reaches its saturation value. A change
  // therefore always needs a full DEBOUNCE_CYCLES of stability.
  always_comb begin
    stable_next = stable_cnt;
    if (btn_sync != btn_prev) begin
      stable_next = 16'd0;
    end else if (stable_cnt != STABLE_MAX) begin
      stable_next = stable_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_cnt <= 16'd0;
      debounced  <= 8'h00;
    end else begin
      stable_cnt <= stable_next;
      if (stable_next == STABLE_MAX) begin
        debounced <= btn_sync;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A latch rise pre-empts everything, including a coincident pulse rise.
  always_comb begin
    state_next = state;
    if (latch_rise) begin
      state_next = LOAD;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        LOAD:    if (latch_fall) state_next = SHIFT;
        SHIFT:   if (pulse_rise && (bit_idx == 3'd7)) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Next-cycle values for the datapath. nes_data always mirrors the bit
  // that the shift register will present after this edge.
  always_comb begin
    load_shift      = 1'b0;
    do_shift        = 1'b0;
    start_frame     = 1'b0;
    finish_frame    = 1'b0;
    nes_data_next   = 1'b1;
    frame_done_next = 1'b0;
    if (latch_rise) begin
      load_shift    = 1'b1;
      nes_data_next = ~debounced[0];
    end else begin
      case (state)
        LOAD: begin
          if (latch_fall) begin
            start_frame   = 1'b1;
            nes_data_next = shift_reg[0];
          end else begin
            load_shift    = 1'b1;
            nes_data_next = ~debounced[0];
          end
        end
        SHIFT: begin
          if (pulse_rise) begin
            do_shift      = 1'b1;
            finish_frame  = (bit_idx == 3'd7);
            nes_data_next = finish_frame ? 1'b1 : shift_reg[1];
          end else begin
            nes_data_next = shift_reg[0];
          end
        end
        default: nes_data_next = 1'b1;
      endcase
    end
    frame_done_next = finish_frame;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg  <= 8'hFF;
      bit_idx    <= 3'd0;
      nes_data_q <= 1'b1;
      frame_done <= 1'b0;
      poll_count <= 8'h00;
    end else begin
      if (load_shift) begin
        shift_reg <= ~debounced;
      end else if (do_shift) begin
        shift_reg <= {1'b1, shift_reg[7:1]};
      end
      if (start_frame) begin
        bit_idx    <= 3'd0;
        poll_count <= poll_count + 8'd1;
      end else if (do_shift) begin
        bit_idx <= bit_idx + 3'd1;
      end
      nes_data_q <= nes_data_next;
      frame_done <= frame_done_next;
    end
  end

  assign nes.nes_data = nes_data_q;

endmodule

// File: tb/tb_nes_controller_responder.sv
// Randomized bench for nes_controller_responder. Expected frames come from
// the button pattern itself: bit k of the frame is the inverse of button k.
module tb_nes_controller_responder;
  localparam logic [15:0] DC = 16'd4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic       frame_done;
  logic [7:0] poll_count;

  int checks = 0;
  int failures = 0;
  int fd_count = 0;
  int poll_exp = 0;

  nes_controller_responder_if nes ();

  nes_controller_responder #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .buttons    (buttons),
    .nes        (nes),
    .frame_done (frame_done),
    .poll_count (poll_count)
  );

  always #5 clk = ~clk;

  // Counts every cycle that frame_done is high, so a stretched pulse shows up.
  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [7:0] btn);
    buttons = btn;
    waitCycles(int'(DC) + 12);
  endtask

  task automatic latchPulse(input int high_cycles, input int low_cycles);
    nes.nes_latch = 1'b1;
    waitCycles(high_cycles);
    nes.nes_latch = 1'b0;
    waitCycles(low_cycles);
  endtask

  task automatic shiftPulse();
    nes.nes_pulse = 1'b1;
    waitCycles(3);
    nes.nes_pulse = 1'b0;
    waitCycles(3);
  endtask

  // Reads pulses 1..n after a latch and checks the bits against the buttons.
  task automatic checkPulses(input logic [7:0] btn, input int first, input int last,
                             input string tag);
    logic e;
    for (int k = first; k <= last; k++) begin
      shiftPulse();
      @(negedge clk);
      e = (k < 8) ? ~btn[k] : 1'b1;
      checkOutput($sformatf("%s bit%0d", tag, k), 32'(nes.nes_data), 32'(e));
    end
  endtask

  task automatic readFrame(input logic [7:0] btn, input int npulses, input string tag);
    int   fd_before;
    logic e;
    fd_before = fd_count;
    latchPulse(6, 5);
    poll_exp = (poll_exp + 1) % 256;
    @(negedge clk);
    e = ~btn[0];
    checkOutput($sformatf("%s A", tag), 32'(nes.nes_data), 32'(e));
    checkPulses(btn, 1, npulses, tag);
    waitCycles(2);
    checkOutput($sformatf("%s frame_done", tag), 32'(fd_count - fd_before),
                (npulses >= 8) ? 32'd1 : 32'd0);
    checkOutput($sformatf("%s poll", tag), 32'(poll_count), 32'(poll_exp));
  endtask

  initial begin
    logic [7:0] b;
    logic       e;
    int         n;
    int         fd_before;

    nes.nes_latch = 1'b0;
    nes.nes_pulse = 1'b0;
    waitCycles(3);
    @(negedge clk);
    checkOutput("reset nes_data", 32'(nes.nes_data), 32'd1);
    checkOutput("reset frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset poll", 32'(poll_count), 32'd0);
    waitCycles(1);
    reset_n = 1'b1;

    applyStimulus(8'h09);
    readFrame(8'h09, 9, "frame09");
    applyStimulus(8'hFF);
    readFrame(8'hFF, 10, "frameFF");

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      n = int'($urandom_range(0, 10));
      applyStimulus(b);
      readFrame(b, n, $sformatf("rand%0d", i));
    end

    // Abort mid-frame with latch and pulse rising together
    b = 8'($urandom) | 8'h01;
    applyStimulus(b);
    fd_before = fd_count;
    latchPulse(6, 5);
    poll_exp = (poll_exp + 1) % 256;
    checkPulses(b, 1, 3, "abort pre");
    nes.nes_latch = 1'b1;
    nes.nes_pulse = 1'b1;
    waitCycles(6);
    nes.nes_pulse = 1'b0;
    @(negedge clk);
    e = ~b[0];
    checkOutput("abort A", 32'(nes.nes_data), 32'(e));
    checkOutput("abort poll held", 32'(poll_count), 32'(poll_exp));
    waitCycles(1);
    nes.nes_latch = 1'b0;
    waitCycles(5);
    poll_exp = (poll_exp + 1) % 256;
    checkOutput("abort poll", 32'(poll_count), 32'(poll_exp));
    checkPulses(b, 1, 8, "abort post");
    waitCycles(2);
    checkOutput("abort frame_done", 32'(fd_count - fd_before), 32'd1);

    // Bouncing A must not get past the debouncer
    applyStimulus(8'h00);
    for (int i = 0; i < 10; i++) begin
      buttons[0] = ~buttons[0];
      waitCycles(3);
      @(negedge clk);
      checkOutput($sformatf("bounce %0d", i), 32'(dut.debounced[0]), 32'd0);
    end
    buttons[0] = 1'b1;
    waitCycles(2);
    @(negedge clk);
    checkOutput("bounce settle early", 32'(dut.debounced[0]), 32'd0);
    waitCycles(int'(DC) + 3);
    @(negedge clk);
    checkOutput("bounce settled", 32'(dut.debounced[0]), 32'd1);
    waitCycles(1);
    readFrame(8'h01, 8, "bounce frame");

    // Reset in the middle of a frame while the latch is held high
    applyStimulus(8'h01);
    latchPulse(6, 5);
    poll_exp = (poll_exp + 1) % 256;
    checkPulses(8'h01, 1, 4, "rst pre");
    nes.nes_latch = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rst nes_data", 32'(nes.nes_data), 32'd1);
    checkOutput("rst poll", 32'(poll_count), 32'd0);
    waitCycles(2);
    reset_n = 1'b1;
    poll_exp = 0;
    waitCycles(int'(DC) + 12);
    @(negedge clk);
    checkOutput("rst held latch", 32'(nes.nes_data), 32'd1);
    waitCycles(1);
    nes.nes_latch = 1'b0;
    waitCycles(5);
    @(negedge clk);
    checkOutput("rst latch low", 32'(nes.nes_data), 32'd1);
    checkOutput("rst latch low poll", 32'(poll_count), 32'd0);
    waitCycles(1);
    readFrame(8'h01, 8, "rst frame");

    // poll_count wrap after 256 latches
    reset_n = 1'b0;
    waitCycles(2);
    reset_n = 1'b1;
    poll_exp = 0;
    applyStimulus(8'hA5);
    for (int i = 0; i < 255; i++) latchPulse(4, 4);
    @(negedge clk);
    checkOutput("wrap 255", 32'(poll_count), 32'd255);
    waitCycles(1);
    latchPulse(4, 4);
    @(negedge clk);
    checkOutput("wrap 0", 32'(poll_count), 32'd0);
    waitCycles(1);
    readFrame(8'hA5, 8, "wrap frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
